// File: rtl/key_scan_debounce_pkg.sv
// Shared definitions for the push-button scanner.
// Per-key filter state encoding and default debounce interval.
package key_scan_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    HELD       = 2'd2,
    REL_FILT   = 2'd3
  } kf_state_e;

  localparam int CNT_MAX_20MS = 999_999;

endpackage

// File: rtl/key_scan_debounce_key_filter.sv
// One push-button: 2-FF synchronizer, edge flop, debounce counter
// and press/release FSM with registered level and pulse outputs.
module key_filter
  import key_scan_debounce_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_20MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic rel_pulse
);

  localparam int CW =
    (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(CNT_MAX - 1);

  logic sync1_q, sync2_q, sync3_q;
  kf_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic rel_q, rel_d;

  logic fall, rise, low;

  assign low  = ~sync2_q;
  assign fall = sync3_q & ~sync2_q;
  assign rise = ~sync3_q & sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Confirm on the clock the count would hit CNT_MAX
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = PRESS_FILT;
          cnt_d   = '0;
        end
      end
      PRESS_FILT: begin
        if (!low) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (rise) begin
          state_d = REL_FILT;
          cnt_d   = '0;
        end
      end
      REL_FILT: begin
        if (low) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level     = level_q;
  assign press     = press_q;
  assign rel_pulse = rel_q;

endmodule

// File: rtl/key_scan_debounce.sv
// Debounced key scanner: per-key filters plus a registered
// lowest-index priority encoder for press events.
module key_scan_debounce
  import key_scan_debounce_pkg::*;
#(
  parameter int NUM_KEYS = 4,
  parameter int CNT_MAX  = CNT_MAX_20MS,
  parameter int IDX_W    = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                key_valid,
  output logic [IDX_W-1:0]    key_index
);

  logic             valid_q, valid_d;
  logic [IDX_W-1:0] index_q, index_d;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_filter #(
      .CNT_MAX(CNT_MAX)
    ) u_filter (
      .clk      (sys_clk),
      .rst_n    (sys_rst_n),
      .key_n    (key_in[g]),
      .level    (key_level[g]),
      .press    (key_press[g]),
      .rel_pulse(key_release[g])
    );
  end

  // Lowest set bit wins when several keys confirm together
  always_comb begin
    valid_d = |key_press;
    index_d = index_q;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_press[i]) index_d = IDX_W'(i);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      valid_q <= 1'b0;
      index_q <= '0;
    end else begin
      valid_q <= valid_d;
      index_q <= index_d;
    end
  end

  assign key_valid = valid_q;
  assign key_index = index_q;

endmodule

// File: tb/tb_key_scan_debounce.sv
// Bench for key_scan_debounce: directed scenarios and random key
// activity against a run-length debounce reference model.
module tb_key_scan_debounce;

  localparam int NK = 4;
  localparam int CM = 9;
  localparam int IW = 2;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic          key_valid;
  logic [IW-1:0] key_index;

  key_scan_debounce #(
    .NUM_KEYS(NK),
    .CNT_MAX (CM),
    .IDX_W   (IW)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_valid  (key_valid),
    .key_index  (key_index)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: raw key delayed two samples, debounced by run length
  logic [NK-1:0] m_h1, m_h2, m_level, m_press, m_rel;
  logic          m_valid;
  logic [IW-1:0] m_index;
  int            m_run[NK];
  int            cnt_press[NK];
  int            cnt_rel[NK];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_h1    = '1;
    m_h2    = '1;
    m_level = '0;
    m_press = '0;
    m_rel   = '0;
    m_valid = 1'b0;
    m_index = '0;
    for (int k = 0; k < NK; k++) m_run[k] = 0;
  endtask

  task automatic model_step();
    logic v;
    m_valid = |m_press;
    for (int k = 0; k < NK; k++) begin
      if (m_press[k]) begin
        m_index = IW'(k);
        break;
      end
    end
    for (int k = 0; k < NK; k++) begin
      v = m_h2[k];
      m_h2[k] = m_h1[k];
      m_h1[k] = key_in[k];
      m_press[k] = 1'b0;
      m_rel[k] = 1'b0;
      // v == level means the input disagrees with the debounced state
      if (v == m_level[k]) begin
        m_run[k]++;
        if (m_run[k] == CM + 1) begin
          m_run[k] = 0;
          if (m_level[k]) m_rel[k] = 1'b1;
          else m_press[k] = 1'b1;
          m_level[k] = ~m_level[k];
        end
      end else begin
        m_run[k] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    if (!sys_rst_n) model_reset();
    else model_step();
    @(negedge sys_clk);
    for (int k = 0; k < NK; k++) begin
      if (key_press[k] === 1'b1) cnt_press[k]++;
      if (key_release[k] === 1'b1) cnt_rel[k]++;
    end
    check("press", 32'(key_press), 32'(m_press));
    check("release", 32'(key_release), 32'(m_rel));
    check("level", 32'(key_level), 32'(m_level));
    check("valid", 32'(key_valid), 32'(m_valid));
    check("index", 32'(key_index), 32'(m_index));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_counts();
    for (int k = 0; k < NK; k++) begin
      cnt_press[k] = 0;
      cnt_rel[k] = 0;
    end
  endtask

  // Clocks until the selected pulse on key k; -1 if none within 40
  task automatic wait_evt(input int k, input bit rel,
                          output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if ((rel ? key_release[k] : key_press[k]) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat;
  int hold[NK];

  initial begin
    clr_counts();
    model_reset();
    sys_rst_n = 1'b0;
    key_in = '0;

    // Reset with every key pressed
    ticks(4);
    check("rst_level", 32'(key_level), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    sys_rst_n = 1'b1;
    wait_evt(0, 1'b0, lat);
    check("rst_lat", 32'(lat), 32'd12);
    check("rst_all", 32'(key_press), 32'hf);
    tick();
    check("rst_idx", 32'(key_index), 32'd0);
    key_in = '1;
    ticks(15);

    // Clean press and release of key 2
    key_in[2] = 1'b0;
    wait_evt(2, 1'b0, lat);
    check("k2_lat", 32'(lat), 32'd12);
    check("k2_press", 32'(key_press), 32'h4);
    check("k2_level", 32'(key_level[2]), 32'h1);
    tick();
    check("k2_valid", 32'(key_valid), 32'h1);
    check("k2_index", 32'(key_index), 32'd2);
    ticks(5);
    key_in[2] = 1'b1;
    wait_evt(2, 1'b1, lat);
    check("k2_rel_lat", 32'(lat), 32'd12);
    check("k2_rel_lvl", 32'(key_level[2]), 32'h0);
    ticks(3);

    // Bounce on key 0, then a final fall
    clr_counts();
    for (int i = 0; i < 5; i++) begin
      key_in[0] = 1'b0;
      ticks(3);
      key_in[0] = 1'b1;
      ticks(3);
    end
    check("bnc_quiet", 32'(cnt_press[0]), 32'd0);
    key_in[0] = 1'b0;
    wait_evt(0, 1'b0, lat);
    check("bnc_lat", 32'(lat), 32'd12);
    check("bnc_once", 32'(cnt_press[0]), 32'd1);
    key_in[0] = 1'b1;
    ticks(15);

    // Keys 1 and 3 together
    key_in[1] = 1'b0;
    key_in[3] = 1'b0;
    wait_evt(1, 1'b0, lat);
    check("sim_lat", 32'(lat), 32'd12);
    check("sim_press", 32'(key_press), 32'ha);
    tick();
    check("sim_valid", 32'(key_valid), 32'h1);
    check("sim_index", 32'(key_index), 32'd1);
    tick();
    check("sim_vdrop", 32'(key_valid), 32'h0);
    check("sim_ihold", 32'(key_index), 32'd1);
    key_in = '1;
    ticks(15);

    // Long hold on key 1: no auto-repeat
    clr_counts();
    key_in[1] = 1'b0;
    ticks(100);
    check("hold_once", 32'(cnt_press[1]), 32'd1);
    check("hold_lvl", 32'(key_level[1]), 32'h1);
    key_in[1] = 1'b1;
    ticks(15);
    check("hold_rel", 32'(cnt_rel[1]), 32'd1);

    // Reset while key 0 is filtering, key still held afterwards
    clr_counts();
    key_in[0] = 1'b0;
    ticks(8);
    sys_rst_n = 1'b0;
    ticks(3);
    check("mid_none", 32'(cnt_press[0]), 32'd0);
    sys_rst_n = 1'b1;
    wait_evt(0, 1'b0, lat);
    check("mid_lat", 32'(lat), 32'd12);
    check("mid_once", 32'(cnt_press[0]), 32'd1);
    key_in[0] = 1'b1;
    ticks(15);

    // Random key activity with one reset pulse
    for (int k = 0; k < NK; k++) hold[k] = 1;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NK; k++) begin
        hold[k]--;
        if (hold[k] == 0) begin
          key_in[k] = ~key_in[k];
          hold[k] = $urandom_range(1, 24);
        end
      end
      if (c == 700) sys_rst_n = 1'b0;
      if (c == 703) sys_rst_n = 1'b1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_scan_debounce.md
Name: key_scan_debounce

Overview:
- Input-side counterpart to the board LED drivers: samples the active-low push buttons and filters contact bounce.
- Emits clean, single-cycle press events plus an encoded key index.
- Feeds pattern, speed and direction control logic of the LED blocks.
- Runs entirely in the 50 MHz system clock domain.

Parameters:
- NUM_KEYS, 4, number of push-button inputs (1..8).
- CNT_MAX, 999_999, debounce interval in clocks minus one (20 ms at 50 MHz); benches override it with a small value.
- IDX_W, 2, width of key_index; must satisfy 2**IDX_W >= NUM_KEYS.

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst_n  input  1  asynchronous active-low reset.
- key_in  input  NUM_KEYS  raw board keys; 0 = pressed; asynchronous to sys_clk.
- key_level  output  NUM_KEYS  debounced level per key; 1 = held.
- key_press  output  NUM_KEYS  one-cycle pulse per key on a confirmed press.
- key_release  output  NUM_KEYS  one-cycle pulse per key on a confirmed release.
- key_valid  output  1  one-cycle pulse when any key_press bit fires.
- key_index  output  IDX_W  index of the pressed key, valid with key_valid; holds its value otherwise.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset sys_rst_n is asynchronous and active-low.
- Reset values:
  - All outputs are 0.
  - Synchronizer flops reset to 1 (released).
  - Counters reset to 0.
  - Every per-key FSM resets to IDLE.
- Synchronizer: 2-FF per key on key_in, then one more flop for edge detection. Raw-to-FSM latency is 2 clocks.
- Per-key FSM, states IDLE, PRESS_FILT, HELD, REL_FILT:
  - IDLE: synced key = 0 -> PRESS_FILT, counter cleared.
  - PRESS_FILT: counter increments each clock while synced = 0. Any synced = 1 -> IDLE, counter cleared. Counter reaches CNT_MAX with synced still 0 -> HELD; key_press pulses for exactly one clock; key_level rises the same clock.
  - HELD: synced = 1 -> REL_FILT, counter cleared.
  - REL_FILT: counter increments while synced = 1. Any synced = 0 -> HELD. Counter reaches CNT_MAX -> IDLE; key_release pulses one clock; key_level falls.
- Counter: width is ceil(log2(CNT_MAX+1)); it never wraps because the FSM leaves the state at CNT_MAX. A steady input therefore confirms CNT_MAX+1 clocks after it reaches the FSM.
- key_valid / key_index:
  - Registered one clock after key_press.
  - key_valid = OR of key_press.
  - key_index = lowest set bit of key_press when several keys confirm in the same cycle. Higher keys are still reported on key_press but are lost from key_index.
  - key_index holds its last value until the next key_valid.
- Holding a key produces no auto-repeat: exactly one key_press per confirmed press.
- Reset mid-filter: all state cleared immediately. A key still held after reset deasserts must go through the full PRESS_FILT again.
- Glitch shorter than CNT_MAX+1 clocks: no pulse, key_level unchanged.

Decomposition:
- Shared package: FSM state encoding (2-bit localparams IDLE=0, PRESS_FILT=1, HELD=2, REL_FILT=3) and default CNT_MAX_20MS=999_999.
- Sub-module key_filter (one key: synchronizer, counter, FSM, press/release/level), instantiated NUM_KEYS times by generate.
- Top level adds the priority encoder and the valid/index register.

Test Plan (CNT_MAX=9 unless stated):
1. Reset: hold sys_rst_n=0 with key_in=4'b0000 -> all outputs 0. After release, first key_press[all] comes 12 clocks later (2 sync + 10 filter), not earlier.
2. Clean press key 2: key_in[2] falls and stays -> key_press=4'b0100 for 1 clock at edge+12; key_level[2]=1. Next clock key_valid=1, key_index=2. Release -> key_release[2] at release+12, key_level[2]=0.
3. Bounce: key_in[0] toggles 0/1 every 3 clocks for 30 clocks, then stays 0 -> no pulse during the bounce; a single key_press[0] 12 clocks after the final fall.
4. Simultaneous: key_in[1] and key_in[3] fall on the same clock -> key_press=4'b1010 in one cycle; key_valid once; key_index=1.
5. Long hold: key_in[1] low for 100 clocks -> exactly one key_press[1], key_level[1] stays 1, no repeat.
6. Reset mid-filter: assert sys_rst_n=0 at clock 6 of PRESS_FILT for key 0 -> no key_press. After reset release, with the key still held, key_press[0] appears 12 clocks later.
